checkpoint_monitor: RTL and testbench
=====================================

# checkpoint_monitor

Synthesizable, parametrised checkpoint-sequence monitor for the user project area. It watches a checkpoint bus driven by firmware onto `mprj_io` (typically `mprj_io[31:16]`). It verifies that a programmable list of codes appears in order, each within a per-stage cycle budget and held stable for a minimum number of cycles. It reports pass, fail or timeout status that firmware or a logic analyser can read back, so in-silicon checks work without a simulation bench.

## Interface
Parameters:
- `WIDTH`, 16: checkpoint bus width.
- `NUM_CP`, 4: number of checkpoint stages (≥1).
- `TMO_W`, 24: width of the timeout budget and counter.
- `STABLE`, 2: consecutive cycles a code must be held to count (≥1).
- `SW`, `$clog2(NUM_CP+1)`: stage index width.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle pulse; arms or re-arms the monitor.
- `checkbits_i` in WIDTH: checkpoint bus under observation.
- `cp_table_i` in NUM_CP*WIDTH: expected codes; stage k is `[k*WIDTH +: WIDTH]`. Must be static while armed.
- `timeout_i` in TMO_W: per-stage budget in cycles; 0 disables the timeout.
- `busy_o` out 1: monitor is armed.
- `pass_o` out 1: all stages hit (sticky).
- `fail_o` out 1: out-of-order code detected (sticky).
- `timeout_o` out 1: stage budget expired (sticky).
- `stage_o` out SW: index of the next expected stage; equals NUM_CP after pass.
- `fail_code_o` out WIDTH: registered bus value at fail or timeout.
- `elapsed_o` out 32: cycles since arming, saturating at 32'hFFFF_FFFF, frozen in terminal states.

## Operation
- `checkbits_i` is registered once into `cb_q`. All compares use `cb_q`.
- `stab_cnt` (saturating at STABLE) increments while `cb_q` equals its previous value. It resets to 1 on any change.
- `hit` = `cb_q == cp[stage]` and `stab_cnt == STABLE`.
- `ooo` = `cb_q == cp[j]` for some j > stage, with `stab_cnt == STABLE`, and not `hit`.
  - Codes of already-passed stages never cause a fail.
  - Duplicate table entries resolve in favour of `hit`.
- FSM states: IDLE, ARMED, PASS, FAIL, TMO.
- IDLE → ARMED on `start_i`. This clears `stage`, `tmo_cnt`, `elapsed`, `fail_code_o` and the sticky flags.
- ARMED, on `hit`:
  - `stage` increments and `tmo_cnt` clears.
  - If it was stage NUM_CP-1, go to PASS.
- ARMED, on `ooo`: go to FAIL and latch `fail_code_o <= cb_q`.
- ARMED, on timeout (`timeout_i != 0`, `tmo_cnt == timeout_i-1`, no `hit` this cycle): go to TMO and latch `fail_code_o <= cb_q`.
- Otherwise ARMED increments `tmo_cnt`.
- Priority in one cycle: `hit` > `ooo` > timeout.
- PASS, FAIL and TMO hold until `start_i`, which re-arms directly to ARMED.
- `start_i` while ARMED restarts from stage 0.
- The stability counter is not cleared on start. A code already held stable counts immediately.
- `busy_o` = state==ARMED. Each flag = its terminal state. All outputs are registered.

## Timing
- Reset values: state IDLE; `busy_o`, `pass_o`, `fail_o`, `timeout_o` = 0; `stage_o` = 0; `fail_code_o` = 0; `elapsed_o` = 0; `cb_q` = 0; `stab_cnt` = 0.
- Reset wins over `start_i` in the same cycle. Reset mid-run returns to IDLE with no flag set.
- Code latency: a value first sampled on `checkbits_i` at edge n lands in `cb_q` at n. `stage_o`, `pass_o` or `fail_o` update at edge n+STABLE, provided the value is held through edge n+STABLE-1.
- Glitches shorter than STABLE cycles are ignored.
- Timeout: with budget T, TMO is entered at the T-th edge after arming or the last advance, unless `hit` occurs on that cycle.
- `start_i` at edge n gives `busy_o` = 1 and `elapsed_o` = 0 after edge n. `elapsed_o` then increments each ARMED cycle.
- On entering PASS, FAIL or TMO, `busy_o` falls and the flag rises at the same edge.

## Test plan
- NUM_CP=2, table {AB60, AB61}, STABLE=2, T=1000. Drive AB60 for 5 cycles, then AB61 for 5 cycles → `stage_o` goes 0→1→2, `pass_o`=1, `busy_o`=0, `fail_o`=`timeout_o`=0.
- Same table, T=100. Drive AB60, then hold 0000 → `timeout_o`=1 exactly 100 cycles after the stage-1 advance; `fail_code_o`=0000, `stage_o`=1.
- Same table. Drive AB61 stable 2 cycles while at stage 0 → `fail_o`=1, `fail_code_o`=AB61, `stage_o`=0.
- STABLE=3. Pulse AB60 for 2 cycles, return to 0000, then hold AB60 for 3 cycles → first pulse ignored; stage advances 3 edges after the second sample.
- Arm, reach stage 1, assert `wb_rst_i` for 1 cycle → all outputs return to reset values. `start_i` then re-arms from stage 0 and a full pass completes.
- T=0, hold 0000 for 5000 cycles → no timeout; `elapsed_o`=5000, `busy_o`=1. `start_i` mid-run → `elapsed_o`=0, `stage_o`=0.

Source files
------------

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: watches a firmware-driven checkpoint bus and checks that a
// programmed list of codes appears in order, held stable, within a per-stage budget.
module checkpoint_monitor #(
    parameter int WIDTH  = 16,
    parameter int NUM_CP = 4,
    parameter int TMO_W  = 24,
    parameter int STABLE = 2,
    parameter int SW     = $clog2(NUM_CP + 1)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start_i,
    input  logic [WIDTH-1:0]        checkbits_i,
    input  logic [NUM_CP*WIDTH-1:0] cp_table_i,
    input  logic [TMO_W-1:0]        timeout_i,
    output logic                    busy_o,
    output logic                    pass_o,
    output logic                    fail_o,
    output logic                    timeout_o,
    output logic [SW-1:0]           stage_o,
    output logic [WIDTH-1:0]        fail_code_o,
    output logic [31:0]             elapsed_o
);
    localparam int STW = $clog2(STABLE + 1);
    localparam logic [STW-1:0] STAB_MAX = STW'(STABLE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PASS  = 3'd2,
        S_FAIL  = 3'd3,
        S_TMO   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cb_q;
    logic [STW-1:0]   stab_q, stab_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      el_q, el_d;
    logic [WIDTH-1:0] fc_q, fc_d;
    logic             busy_q, pass_q, fail_q, tflag_q;
    logic             stable_s, hit_s, ahead_s, ooo_s, expire_s;

    // Stability counter: restarts at 1 whenever the sampled bus changes
    always_comb begin
        if (checkbits_i != cb_q) begin
            stab_d = STW'(1);
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + STW'(1);
        end
    end

    // Match the stable sampled code against the current and all later stages
    always_comb begin
        stable_s = (stab_q == STAB_MAX);
        hit_s    = 1'b0;
        ahead_s  = 1'b0;
        for (int j = 0; j < NUM_CP; j++) begin
            hit_s   = hit_s   | (stable_s && (cb_q == cp_table_i[j*WIDTH +: WIDTH]) && (SW'(j) == stage_q));
            ahead_s = ahead_s | (stable_s && (cb_q == cp_table_i[j*WIDTH +: WIDTH]) && (SW'(j) >  stage_q));
        end
        // a duplicate entry that also matches the current stage counts as progress
        ooo_s    = ahead_s & ~hit_s;
        expire_s = (timeout_i != {TMO_W{1'b0}}) && (tmo_q == (timeout_i - TMO_W'(1)));
    end

    // Next-state logic: start always re-arms, otherwise only ARMED evolves
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        tmo_d   = tmo_q;
        el_d    = el_q;
        fc_d    = fc_q;
        if (start_i) begin
            state_d = S_ARMED;
            stage_d = {SW{1'b0}};
            tmo_d   = {TMO_W{1'b0}};
            el_d    = 32'd0;
            fc_d    = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_ARMED: begin
                    el_d = (el_q == 32'hFFFF_FFFF) ? el_q : el_q + 32'd1;
                    if (hit_s) begin
                        stage_d = stage_q + SW'(1);
                        tmo_d   = {TMO_W{1'b0}};
                        state_d = (stage_q == SW'(NUM_CP - 1)) ? S_PASS : S_ARMED;
                    end else if (ooo_s) begin
                        state_d = S_FAIL;
                        fc_d    = cb_q;
                    end else if (expire_s) begin
                        state_d = S_TMO;
                        fc_d    = cb_q;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, counters and registered status flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cb_q    <= {WIDTH{1'b0}};
            stab_q  <= {STW{1'b0}};
            stage_q <= {SW{1'b0}};
            tmo_q   <= {TMO_W{1'b0}};
            el_q    <= 32'd0;
            fc_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cb_q    <= checkbits_i;
            stab_q  <= stab_d;
            stage_q <= stage_d;
            tmo_q   <= tmo_d;
            el_q    <= el_d;
            fc_q    <= fc_d;
            busy_q  <= (state_d == S_ARMED);
            pass_q  <= (state_d == S_PASS);
            fail_q  <= (state_d == S_FAIL);
            tflag_q <= (state_d == S_TMO);
        end
    end

    assign busy_o      = busy_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = tflag_q;
    assign stage_o     = stage_q;
    assign fail_code_o = fc_q;
    assign elapsed_o   = el_q;
endmodule

// File: tb/tb_checkpoint_monitor.sv
// Bench for checkpoint_monitor: directed scenarios plus random episodes, all
// checked every cycle against a sample-history reference model.
module tb_checkpoint_monitor;
    localparam int WIDTH  = 16;
    localparam int NUM_CP = 4;
    localparam int TMO_W  = 24;
    localparam int STABLE = 3;
    localparam int SW     = $clog2(NUM_CP + 1);

    logic                    clk = 1'b0;
    logic                    rst, start;
    logic [WIDTH-1:0]        cb;
    logic [NUM_CP*WIDTH-1:0] tbl;
    logic [TMO_W-1:0]        tmo;
    logic                    busy_o, pass_o, fail_o, timeout_o;
    logic [SW-1:0]           stage_o;
    logic [WIDTH-1:0]        fail_code_o;
    logic [31:0]             elapsed_o;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: mode 0 idle, 1 armed, 2 pass, 3 fail, 4 timeout
    int               m_mode, m_stage, m_since;
    logic [31:0]      m_el;
    logic [WIDTH-1:0] m_fc;
    logic [WIDTH-1:0] hist [$];
    logic [WIDTH-1:0] pool [0:4];

    always #5 clk = ~clk;

    checkpoint_monitor #(
        .WIDTH(WIDTH), .NUM_CP(NUM_CP), .TMO_W(TMO_W), .STABLE(STABLE), .SW(SW)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .checkbits_i(cb),
        .cp_table_i(tbl), .timeout_i(tmo), .busy_o(busy_o), .pass_o(pass_o),
        .fail_o(fail_o), .timeout_o(timeout_o), .stage_o(stage_o),
        .fail_code_o(fail_code_o), .elapsed_o(elapsed_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] code(input int k);
        return tbl[k*WIDTH +: WIDTH];
    endfunction

    // One clock edge of the model, using the inputs present before the edge
    task automatic model_edge();
        logic [WIDTH-1:0] cur;
        bit stable, adv, ahead;
        if (rst) begin
            m_mode = 0; m_stage = 0; m_since = 0; m_el = 32'd0; m_fc = '0;
            hist.delete();
            return;
        end
        cur    = (hist.size() > 0) ? hist[$] : '0;
        stable = (hist.size() == STABLE);
        foreach (hist[i]) if (hist[i] != cur) stable = 1'b0;
        if (start) begin
            m_mode = 1; m_stage = 0; m_since = 0; m_el = 32'd0; m_fc = '0;
        end else if (m_mode == 1) begin
            if (m_el != 32'hFFFF_FFFF) m_el = m_el + 32'd1;
            adv   = stable && (cur == code(m_stage));
            ahead = 1'b0;
            for (int j = m_stage + 1; j < NUM_CP; j++)
                if (stable && cur == code(j)) ahead = 1'b1;
            if (adv) begin
                m_stage++;
                m_since = 0;
                if (m_stage == NUM_CP) m_mode = 2;
            end else if (ahead) begin
                m_mode = 3; m_fc = cur;
            end else begin
                m_since++;
                if (tmo != 0 && m_since == int'(tmo)) begin
                    m_mode = 4; m_fc = cur;
                end
            end
        end
        hist.push_back(cb);
        if (hist.size() > STABLE) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy",      32'(busy_o),      32'(m_mode == 1));
        chk("pass",      32'(pass_o),      32'(m_mode == 2));
        chk("fail",      32'(fail_o),      32'(m_mode == 3));
        chk("timeout",   32'(timeout_o),   32'(m_mode == 4));
        chk("stage",     32'(stage_o),     32'(m_stage));
        chk("fail_code", 32'(fail_code_o), 32'(m_fc));
        chk("elapsed",   elapsed_o,        m_el);
    endtask

    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        cb = v;
        repeat (n) step();
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int adv_at, tmo_at, n;
        rst = 1'b1; start = 1'b0; cb = '0; tmo = 24'd1000;
        tbl = {16'hAB63, 16'hAB62, 16'hAB61, 16'hAB60};
        step(); step();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_stage", 32'(stage_o), 32'd0);
        chk("rst_elapsed", elapsed_o, 32'd0);
        rst = 1'b0;
        hold(16'h0000, 3);

        // in-order pass
        arm();
        hold(16'hAB60, 5); hold(16'hAB61, 5); hold(16'hAB62, 5); hold(16'hAB63, 5);
        chk("tp_pass", 32'(pass_o), 32'd1);
        chk("tp_pass_stage", 32'(stage_o), 32'(NUM_CP));
        chk("tp_pass_busy", 32'(busy_o), 32'd0);

        // timeout exactly T edges after the stage-1 advance
        tmo = 24'd100; cb = 16'hAB60; arm();
        adv_at = -1; tmo_at = -1;
        for (int i = 1; i <= 150; i++) begin
            if (i == 5) cb = 16'h0000;
            step();
            if (stage_o == SW'(1) && adv_at < 0) adv_at = i;
            if (timeout_o && tmo_at < 0) tmo_at = i;
        end
        chk("tp_tmo_gap", 32'(tmo_at - adv_at), 32'd100);
        chk("tp_tmo_code", 32'(fail_code_o), 32'h0000);
        chk("tp_tmo_stage", 32'(stage_o), 32'd1);

        // out-of-order code
        arm();
        hold(16'hAB61, 4);
        chk("tp_ooo_fail", 32'(fail_o), 32'd1);
        chk("tp_ooo_code", 32'(fail_code_o), 32'hAB61);
        chk("tp_ooo_stage", 32'(stage_o), 32'd0);

        // glitch shorter than STABLE is ignored, held code lands STABLE edges later
        cb = 16'h0000; arm();
        hold(16'hAB60, 2); hold(16'h0000, 2);
        chk("tp_glitch", 32'(stage_o), 32'd0);
        hold(16'hAB60, 3);
        chk("tp_lat_early", 32'(stage_o), 32'd0);
        step();
        chk("tp_lat", 32'(stage_o), 32'd1);

        // reset mid-run, then a full re-armed pass
        rst = 1'b1; step(); rst = 1'b0;
        chk("tp_rst_stage", 32'(stage_o), 32'd0);
        chk("tp_rst_busy", 32'(busy_o), 32'd0);
        chk("tp_rst_flags", 32'({pass_o, fail_o, timeout_o}), 32'd0);
        tmo = 24'd1000; cb = 16'h0000; arm();
        hold(16'hAB60, 4); hold(16'hAB61, 4); hold(16'hAB62, 4); hold(16'hAB63, 4);
        chk("tp_rearm_pass", 32'(pass_o), 32'd1);

        // timeout disabled
        tmo = 24'd0; cb = 16'h0000; arm();
        hold(16'h0000, 5000);
        chk("tp_t0_elapsed", elapsed_o, 32'd5000);
        chk("tp_t0_busy", 32'(busy_o), 32'd1);
        arm();
        chk("tp_t0_restart_el", elapsed_o, 32'd0);
        chk("tp_t0_restart_stage", 32'(stage_o), 32'd0);

        // random episodes
        for (int e = 0; e < 40; e++) begin
            for (int k = 0; k < 5; k++) pool[k] = WIDTH'($urandom);
            if ($urandom_range(0, 1) == 0) pool[0] = '0;
            tbl = {pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                   pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)]};
            tmo = TMO_W'($urandom_range(0, 25));
            arm();
            for (int s = 0; s < 30; s++) begin
                cb = pool[$urandom_range(0, 4)];
                if ($urandom_range(0, 19) == 0) start = 1'b1;
                if ($urandom_range(0, 59) == 0) rst = 1'b1;
                n = int'($urandom_range(1, 5));
                step();
                start = 1'b0;
                rst   = 1'b0;
                repeat (n - 1) step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
